servo_ramp_ctrl: RTL
====================

Name: servo_ramp_ctrl

Overview:
- Controller that sequences the PWM_Parametrizado generator for the remote-servo path.
- Accepts position commands over a valid/ready interface and maps each position to a pulse width in clocks.
- Moves the driven pulse width toward the target by a bounded step once per PWM frame (slew limiting).
- Drives `duty_cycle` and `period` to the PWM, updating only at frame boundaries so a frame is never glitched.

Parameters:
- WIDTH, 20, bit width of `duty_cycle`, `period` and all pulse arithmetic.
- PERIOD, 1000000, PWM frame length in clocks (20 ms at 50 MHz).
- MIN_PULSE, 50000, pulse width in clocks for position 0.
- MAX_PULSE, 100000, upper clamp on pulse width in clocks.
- PULSE_LSB, 196, clocks added per position LSB.
- POS_W, 8, position command width.
- RAMP_STEP, 1000, maximum pulse-width change per frame, in clocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = drive servo; 0 = output 0 % duty (servo limp).
- cmd_valid  in  1  position command valid.
- cmd_ready  out  1  command accept.
- cmd_pos  in  POS_W  commanded position.
- duty_cycle  out  WIDTH  to PWM `duty_cycle`.
- period  out  WIDTH  to PWM `period`; constant PERIOD after reset.
- frame_start  out  1  one-cycle strobe on the first cycle of each frame.
- busy  out  1  state RAMP.
- at_target  out  1  current pulse == target pulse and state != OFF.

Behaviour:
- **Reset values:**
  - Outputs: `duty_cycle`=0, `period`=0, `cmd_ready`=0, `frame_start`=0, `busy`=0, `at_target`=0.
  - Internal: state=OFF, frame counter fcnt=0.
  - cur and tgt both = pulse(2^(POS_W-1)), the center position.
- **Cycle after reset release:** `period`=PERIOD and `cmd_ready`=1. `cmd_ready` stays 1 until the next reset; commands are accepted in every state, including OFF.
- **Frame counter:**
  - fcnt counts 0..PERIOD-1 and wraps to 0; it runs from reset release, in lockstep with the PWM counter.
  - Boundary = the cycle with fcnt==PERIOD-1.
  - `frame_start` is registered and high on the cycle fcnt==0.
- **Pulse mapping:**
  - pulse(p) = MIN_PULSE + p*PULSE_LSB, computed at WIDTH+POS_W bits, then clamped to MAX_PULSE.
  - Truncation to WIDTH happens only after the clamp.
- **Command:**
  - On `cmd_valid` & `cmd_ready`, tgt <= pulse(`cmd_pos`) at that edge.
  - A new command overrides the target at any time, including mid-ramp.
  - If accepted on a boundary cycle, that boundary's step still uses the old tgt.
- **Ramp step (at each boundary, only when enable=1):**
  - cur<tgt: cur <= min(cur+RAMP_STEP, tgt).
  - cur>tgt: cur <= max(cur-RAMP_STEP, tgt), using WIDTH+1-bit signed compare; no underflow.
  - cur==tgt: no change.
- **Duty update:** `duty_cycle` is loaded at the boundary edge, so the PWM sees the new value on its counter==0 cycle.
  - enable=1: `duty_cycle` <= the new cur value.
  - enable=0: `duty_cycle` <= 0.
- **States (transitions taken at boundaries only; sampled enable):**
  - OFF:
    - enable=1 and cur!=tgt -> RAMP.
    - enable=1 and cur==tgt -> IDLE.
  - IDLE:
    - enable=0 -> OFF.
    - cur!=tgt -> RAMP.
  - RAMP:
    - enable=0 -> OFF; cur is frozen.
    - new cur==tgt -> IDLE.
- **Status outputs:** `busy` and `at_target` are registered from the next-state/next-cur values and are valid from the cycle after the boundary.
- **enable toggling:** enable changes between boundaries have no effect until the next boundary.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). The PWM shares `rst_n`, so frame alignment is preserved.

Decomposition:
- **Package `servo_pkg`:**
  - State encoding OFF/IDLE/RAMP, 2 bits.
  - A function pulse_of(pos) implementing the map-and-clamp.
  - Default timing constants.
- **Sub-module `servo_frame_timer`:**
  - Parameters WIDTH, PERIOD.
  - Outputs: boundary strobe and registered `frame_start`.
  - The same timer is reusable by other frame-synchronous blocks.

Test Plan:
Bench parameters: WIDTH=12, PERIOD=200, MIN_PULSE=10, MAX_PULSE=36, PULSE_LSB=2, POS_W=4, RAMP_STEP=4. Center = 26.
- Reset held, then released -> all outputs 0 during reset; next cycle `period`=200, `cmd_ready`=1; `duty_cycle` stays 0 while enable=0.
- enable=1, no command -> at first boundary `duty_cycle`=26; `at_target`=1, `busy`=0 next cycle; `frame_start` every 200 cycles.
- From 26, cmd_pos=0 -> successive frames `duty_cycle` 22, 18, 14, 10; `busy`=1 during ramp; `at_target`=1 after the 10 frame.
- From 10, cmd_pos=15 (raw 40, clamped 36) -> 14, 18, ..., 34, then 36; never exceeds 36.
- enable=0 mid-ramp at cur=18 -> next frame `duty_cycle`=0, state OFF; re-enable -> 22 at following boundary, ramp resumes.
- cmd_pos=0 accepted exactly on the boundary cycle while at 26 (tgt 26) -> that frame stays 26; next frame 22.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo ramp controller: state encoding,
// default timing constants and the position-to-pulse map.
package servo_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_IDLE = 2'd1,
        S_RAMP = 2'd2
    } servo_state_e;

    localparam int DEF_WIDTH     = 20;
    localparam int DEF_PERIOD    = 1000000;
    localparam int DEF_MIN_PULSE = 50000;
    localparam int DEF_MAX_PULSE = 100000;
    localparam int DEF_PULSE_LSB = 196;
    localparam int DEF_POS_W     = 8;
    localparam int DEF_RAMP_STEP = 1000;

    // Wide arithmetic so the clamp sees the true value; callers truncate afterwards.
    function automatic logic [63:0] pulse_of(input logic [63:0] pos,
                                             input logic [63:0] min_p,
                                             input logic [63:0] lsb,
                                             input logic [63:0] max_p);
        logic [63:0] raw;
        raw = min_p + pos * lsb;
        return (raw > max_p) ? max_p : raw;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; flags the last cycle of each frame and
// strobes frame_start on the first cycle of the next one.
module servo_frame_timer #(
    parameter int WIDTH  = 20,
    parameter int PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic boundary_o,
    output logic frame_start_o
);

    logic [WIDTH-1:0] fcnt_q;
    logic             frame_start_q;

    assign boundary_o    = (fcnt_q == WIDTH'(PERIOD - 1));
    assign frame_start_o = frame_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            fcnt_q        <= boundary_o ? '0 : fcnt_q + 1'b1;
            frame_start_q <= boundary_o;
        end
    end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo PWM sequencer: maps position commands to pulse widths and slews the
// driven duty toward the target by at most RAMP_STEP per frame.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int MAX_PULSE = DEF_MAX_PULSE,
    parameter int PULSE_LSB = DEF_PULSE_LSB,
    parameter int POS_W     = DEF_POS_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_pos,
    output logic [WIDTH-1:0] duty_cycle,
    output logic [WIDTH-1:0] period,
    output logic             frame_start,
    output logic             busy,
    output logic             at_target
);

    localparam logic [WIDTH-1:0] CENTER = WIDTH'(pulse_of(64'(1) << (POS_W - 1),
        64'(MIN_PULSE), 64'(PULSE_LSB), 64'(MAX_PULSE)));
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(RAMP_STEP);

    servo_state_e     state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d, tgt_q, tgt_d, duty_q, duty_d, period_q;
    logic             ready_q, busy_q, at_tgt_q;
    logic             boundary;
    logic [WIDTH-1:0] cmd_pulse, step_cur;
    logic [WIDTH:0]   up_w, dn_w;

    servo_frame_timer #(.WIDTH(WIDTH), .PERIOD(PERIOD)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .boundary_o   (boundary),
        .frame_start_o(frame_start)
    );

    assign cmd_pulse = WIDTH'(pulse_of(64'(cmd_pos), 64'(MIN_PULSE),
                                       64'(PULSE_LSB), 64'(MAX_PULSE)));

    // One extra bit keeps the up/down steps from wrapping; down uses a signed compare.
    always_comb begin
        up_w     = {1'b0, cur_q} + STEP_X;
        dn_w     = {1'b0, cur_q} - STEP_X;
        step_cur = cur_q;
        if (cur_q < tgt_q)
            step_cur = (up_w >= {1'b0, tgt_q}) ? tgt_q : up_w[WIDTH-1:0];
        else if (cur_q > tgt_q)
            step_cur = ($signed(dn_w) <= $signed({1'b0, tgt_q})) ? tgt_q : dn_w[WIDTH-1:0];
    end

    // The boundary step uses the pre-command target; state decisions see the new one.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        duty_d  = duty_q;
        tgt_d   = (cmd_valid && ready_q) ? cmd_pulse : tgt_q;
        if (boundary) begin
            if (enable) cur_d = step_cur;
            duty_d = enable ? cur_d : '0;
            case (state_q)
                S_OFF:   if (enable) state_d = (cur_d != tgt_d) ? S_RAMP : S_IDLE;
                S_IDLE:  if (!enable) state_d = S_OFF;
                         else if (cur_d != tgt_d) state_d = S_RAMP;
                S_RAMP:  if (!enable) state_d = S_OFF;
                         else if (cur_d == tgt_d) state_d = S_IDLE;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            cur_q    <= CENTER;
            tgt_q    <= CENTER;
            duty_q   <= '0;
            period_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            at_tgt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            duty_q   <= duty_d;
            period_q <= WIDTH'(PERIOD);
            ready_q  <= 1'b1;
            busy_q   <= (state_d == S_RAMP);
            at_tgt_q <= (state_d != S_OFF) && (cur_d == tgt_d);
        end
    end

    assign duty_cycle = duty_q;
    assign period     = period_q;
    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign at_target  = at_tgt_q;

endmodule
